// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared USB definitions used by the transmit-side blocks.
//   tx_packet_t      : packet kind requested from usb_TX
//   MAX_PACKET_BYTES : largest full-speed bulk payload
//   byte_t           : one payload byte
// -----------------------------------------------------------------------------
package usb_pkg;

  typedef enum logic [1:0] {
    TX_ACK  = 2'b00,
    TX_NAK  = 2'b01,
    TX_DATA = 2'b10,
    TX_IDLE = 2'b11
  } tx_packet_t;

  localparam int MAX_PACKET_BYTES = 64;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/usb_tx_data_buffer_fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// ADDR_W-bit wrap-around pointer for the transmit byte FIFO.
// The pointer wraps from 2**ADDR_W-1 to 0 by natural overflow.
// Ports:
//   clk    : clock, rising edge
//   n_rst  : asynchronous active-low reset (pointer -> 0)
//   clear  : synchronous clear, dominates en
//   en     : advance the pointer by one
//   ptr    : current pointer value (registered)
// -----------------------------------------------------------------------------
module fifo_ptr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_r;

  // Pointer register: reset, clear, or increment with natural wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_r <= {ADDR_W{1'b0}};
    end else if (clear) begin
      ptr_r <= {ADDR_W{1'b0}};
    end else if (en) begin
      ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/usb_tx_data_buffer.sv
// -----------------------------------------------------------------------------
// usb_tx_data_buffer
// First-word-fall-through byte FIFO feeding usb_TX. Endpoint logic pushes
// payload bytes; usb_TX pops one byte per get_TX_packet_data pulse while it
// serialises a DATA packet. The head byte is always visible on TX_packet_data.
// Ports:
//   clk                : clock, all state on rising edge
//   n_rst              : asynchronous active-low reset
//   clear              : synchronous flush (pointers, occupancy, error flags)
//   store_tx_data      : push strobe, one byte per cycle
//   tx_data            : byte to push
//   get_TX_packet_data : pop strobe from usb_TX
//   TX_packet_data     : head byte, 8'h00 when empty
//   buffer_occupancy   : bytes stored, 0..DEPTH
//   full / empty       : occupancy == DEPTH / occupancy == 0
//   overflow_err       : sticky, push attempted while full
//   underflow_err      : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module usb_tx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = MAX_PACKET_BYTES,
  parameter int ADDR_W = 6,
  parameter int OCC_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [7:0]       tx_data,
  input  logic             get_TX_packet_data,
  output logic [7:0]       TX_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  byte_t             mem_r [DEPTH];
  logic [ADDR_W-1:0] wptr_s;
  logic [ADDR_W-1:0] rptr_s;
  logic [OCC_W-1:0]  occ_r;
  logic              ovf_r;
  logic              unf_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  byte_t             head_s;

  // Flags decode straight from the registered occupancy, so they track it
  // with no added latency.
  assign full_s  = (occ_r == OCC_W'(DEPTH));
  assign empty_s = (occ_r == {OCC_W{1'b0}});

  // A push into a full FIFO or a pop from an empty one is suppressed here;
  // in particular push+pop on an empty FIFO only pushes (no bypass).
  assign push_s = store_tx_data && !full_s;
  assign pop_s  = get_TX_packet_data && !empty_s;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (push_s),
    .ptr   (wptr_s)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .en    (pop_s),
    .ptr   (rptr_s)
  );

  // Storage array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      mem_r[wptr_s] <= tx_data;
    end
  end

  // Occupancy counter: +1 push only, -1 pop only, hold otherwise.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (clear) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (push_s && !pop_s) begin
      occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
    end else if (pop_s && !push_s) begin
      occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
    end else begin
      occ_r <= occ_r;
    end
  end

  // Sticky error flags; only reset or clear removes them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else if (clear) begin
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (store_tx_data & full_s);
      unf_r <= unf_r | (get_TX_packet_data & empty_s);
    end
  end

  // Head-of-queue read: zero latency, forced to 8'h00 when nothing is stored.
  always_comb begin
    head_s = 8'h00;
    if (empty_s) begin
      head_s = 8'h00;
    end else begin
      head_s = mem_r[rptr_s];
    end
  end

  assign TX_packet_data   = head_s;
  assign buffer_occupancy = occ_r;
  assign full             = full_s;
  assign empty            = empty_s;
  assign overflow_err     = ovf_r;
  assign underflow_err    = unf_r;

endmodule

// File: tb/tb_usb_tx_data_buffer.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_data_buffer
// Directed self-checking bench for usb_tx_data_buffer.
// -----------------------------------------------------------------------------
module tb_usb_tx_data_buffer;
  import usb_pkg::*;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_TX_packet_data;
  logic [7:0] TX_packet_data;
  logic [6:0] buffer_occupancy;
  logic       full;
  logic       empty;
  logic       overflow_err;
  logic       underflow_err;

  int checks   = 0;
  int failures = 0;

  byte_t      model_q [$];
  tx_packet_t pkt;
  int         pkt_size;

  usb_tx_data_buffer dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .clear              (clear),
    .store_tx_data      (store_tx_data),
    .tx_data            (tx_data),
    .get_TX_packet_data (get_TX_packet_data),
    .TX_packet_data     (TX_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .full               (full),
    .empty              (empty),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given strobes; returns 1 time unit after the edge.
  task automatic step(input logic clr, input logic push, input logic [7:0] data, input logic pop);
    clear              = clr;
    store_tx_data      = push;
    tx_data            = data;
    get_TX_packet_data = pop;
    @(posedge clk);
    #1;
    clear              = 1'b0;
    store_tx_data      = 1'b0;
    tx_data            = 8'h00;
    get_TX_packet_data = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_occ"},   32'(buffer_occupancy), 32'd0);
    chk({tag, "_empty"}, 32'(empty),            32'd1);
    chk({tag, "_full"},  32'(full),             32'd0);
    chk({tag, "_data"},  32'(TX_packet_data),   32'h00);
    chk({tag, "_ovf"},   32'(overflow_err),     32'd0);
    chk({tag, "_unf"},   32'(underflow_err),    32'd0);
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; store_tx_data = 1'b0; tx_data = 8'h00;
    get_TX_packet_data = 1'b0; pkt = TX_IDLE; pkt_size = 0;

    // ---- 1: reset, then reset mid-burst ----
    #12;
    chk_idle("rst_init");
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);   // underflow
    step(1'b0, 1'b1, 8'h77, 1'b0);
    chk("pre_rst_occ", 32'(buffer_occupancy), 32'd1);
    chk("pre_rst_unf", 32'(underflow_err),    32'd1);
    store_tx_data = 1'b1; tx_data = 8'h88;
    #2 n_rst = 1'b0;
    #1;
    chk_idle("rst_mid");
    store_tx_data = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;

    // ---- 2: push four, pop four in order ----
    step(1'b0, 1'b1, 8'hCC, 1'b0);
    chk("t2_first_visible", 32'(TX_packet_data), 32'hCC);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    chk("t2_occ4", 32'(buffer_occupancy), 32'd4);
    chk("t2_head0", 32'(TX_packet_data), 32'hCC);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_head1", 32'(TX_packet_data), 32'h01);
    chk("t2_occ3",  32'(buffer_occupancy), 32'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_head2", 32'(TX_packet_data), 32'h02);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t2_head3", 32'(TX_packet_data), 32'h03);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk_idle("t2_end");

    // ---- 3: fill to 64, overflow, drain ----
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    chk("t3_full", 32'(full),             32'd1);
    chk("t3_occ",  32'(buffer_occupancy), 32'd64);
    chk("t3_ovf0", 32'(overflow_err),     32'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("t3_ovf1",    32'(overflow_err),     32'd1);
    chk("t3_occ_hold", 32'(buffer_occupancy), 32'd64);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("t3_rd%0d", i), 32'(TX_packet_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("t3_empty", 32'(empty),           32'd1);
    chk("t3_data0", 32'(TX_packet_data),  32'h00);
    chk("t3_ovf_sticky", 32'(overflow_err), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk_idle("t3_clear");

    // ---- 4: pointer wrap ----
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("t4a_rd%0d", i), 32'(TX_packet_data), 32'(8'h40 + i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    chk("t4_occ40", 32'(buffer_occupancy), 32'd40);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("t4b_rd%0d", i), 32'(TX_packet_data), 32'(8'h80 + i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk_idle("t4_end");

    // ---- 5: simultaneous push+pop ----
    model_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
      model_q.push_back(8'(8'hA0 + i));
    end
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("t5_head%0d", i), 32'(TX_packet_data), 32'(model_q[0]));
      step(1'b0, 1'b1, 8'(8'hB0 + i), 1'b1);
      void'(model_q.pop_front());
      model_q.push_back(8'(8'hB0 + i));
      chk($sformatf("t5_occ%0d", i), 32'(buffer_occupancy), 32'd10);
    end
    while (model_q.size() > 0) begin
      chk("t5_drain", 32'(TX_packet_data), 32'(model_q[0]));
      step(1'b0, 1'b0, 8'h00, 1'b1);
      void'(model_q.pop_front());
    end
    chk("t5_empty", 32'(empty),        32'd1);
    chk("t5_unf0",  32'(underflow_err), 32'd0);
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    chk("t5_occ1",  32'(buffer_occupancy), 32'd1);
    chk("t5_unf1",  32'(underflow_err),    32'd1);
    chk("t5_head",  32'(TX_packet_data),   32'h5A);

    // ---- 6: clear with push+pop, then a 2-byte DATA packet ----
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
    chk("t6_occ5", 32'(buffer_occupancy), 32'd5);
    step(1'b0, 1'b0, 8'h00, 1'b1);   // pop while non-empty, no error
    step(1'b0, 1'b1, 8'hE0, 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    chk_idle("t6_clear");
    step(1'b0, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    pkt      = TX_DATA;
    pkt_size = int'(buffer_occupancy);
    chk("t6_pkt", 32'(pkt), 32'(TX_DATA));
    chk("t6_size", 32'(pkt_size), 32'd2);
    chk("t6_b0", 32'(TX_packet_data), 32'h11);
    for (int i = 0; i < pkt_size; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    pkt = TX_IDLE;
    chk_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
